// File: rtl/bram_wr_arb.sv
// bram_wr_arb: two-requester round-robin write arbiter in front of a single
// BRAM write port, with a built-in sequencer that fills the whole memory with
// a constant value.
//
// Clear FSM states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | requesters arbitrated; clear_start launches a fill
//   ST_CLEAR | fill in progress, one word per cycle, requesters blocked
//
// The fill word is held in bram_data_q for the whole sequence, so no separate
// latch register is needed for clear_data.
module bram_wr_arb #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [ADDRW-1:0] a_addr,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [ADDRW-1:0] b_addr,
    input  logic [WIDTH-1:0] b_data,
    input  logic             clear_start,
    input  logic [WIDTH-1:0] clear_data,
    output logic             clear_busy,
    output logic             clear_done,
    output logic             bram_we,
    output logic [ADDRW-1:0] bram_addr,
    output logic [WIDTH-1:0] bram_data
);

    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_CLEAR  = 1'b1;
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

    logic [0:0]       state_q, state_d;
    logic [ADDRW-1:0] cnt_q, cnt_d;
    logic             last_b_q, last_b_d;
    logic             we_q, we_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             blocked;
    logic             a_grant;
    logic             b_grant;

    // Round-robin grant; on a tie the requester not granted last wins.
    always_comb begin
        blocked = rst || (state_q == ST_CLEAR) || clear_start;
        a_grant = !blocked && a_valid && (!b_valid || last_b_q);
        b_grant = !blocked && b_valid && (!a_valid || !last_b_q);
    end

    assign a_ready    = a_grant;
    assign b_ready    = b_grant;
    assign clear_busy = (state_q == ST_CLEAR);
    assign clear_done = done_q;
    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_data  = data_q;

    // Next-state for the clear sequencer, write-port register and last grant.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    we_d    = 1'b1;
                    addr_d  = '0;
                    data_d  = clear_data;
                end else if (a_grant) begin
                    we_d     = 1'b1;
                    addr_d   = a_addr;
                    data_d   = a_data;
                    last_b_d = 1'b0;
                end else if (b_grant) begin
                    we_d     = 1'b1;
                    addr_d   = b_addr;
                    data_d   = b_data;
                    last_b_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                // cnt_q is the address currently on the write port; the
                // sequence ends once the last address has been presented.
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + ADDRW'(1);
                    we_d   = 1'b1;
                    addr_d = cnt_q + ADDRW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset; last grant resets to B so A
    // wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_bram_wr_arb.sv
// Testbench for bram_wr_arb (DEPTH=200 to exercise a non-power-of-two fill).
module tb_bram_wr_arb;

    localparam int WIDTH = 8;
    localparam int DEPTH = 200;
    localparam int ADDRW = 8;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_valid = 1'b0;
    logic             a_ready;
    logic [ADDRW-1:0] a_addr = '0;
    logic [WIDTH-1:0] a_data = '0;
    logic             b_valid = 1'b0;
    logic             b_ready;
    logic [ADDRW-1:0] b_addr = '0;
    logic [WIDTH-1:0] b_data = '0;
    logic             clear_start = 1'b0;
    logic [WIDTH-1:0] clear_data = '0;
    logic             clear_busy;
    logic             clear_done;
    logic             bram_we;
    logic [ADDRW-1:0] bram_addr;
    logic [WIDTH-1:0] bram_data;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  m_last_b = 1'b1;
    wr_t exp_q[$];
    wr_t mon_e;

    bram_wr_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .clear_start(clear_start), .clear_data(clear_data),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_data(bram_data)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every write on the BRAM port must match the queue head.
    always @(posedge clk) begin
        #2;
        if (bram_we !== 1'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: got we=%b addr=%0h data=%0h, required no write",
                         bram_we, bram_addr, bram_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bram_addr, bram_data} !== {mon_e.addr, mon_e.data}) begin
                    n_err++;
                    $display("FAIL wr_data: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             bram_addr, bram_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [1:0] exp_grant(input logic av, input logic bv);
        if (av && bv) return m_last_b ? 2'b10 : 2'b01;
        return {av, bv};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b1; a_addr = 8'h10; a_data = 8'h11;
        b_valid = 1'b1; b_addr = 8'h20; b_data = 8'h22;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bram_we, bram_addr, bram_data, clear_busy, clear_done, a_ready, b_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got we=%b addr=%0h data=%0h busy=%b done=%b ar=%b br=%b, required all 0",
                     bram_we, bram_addr, bram_data, clear_busy, clear_done, a_ready, b_ready);
        end
        m_last_b = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            g = exp_grant(1'b1, 1'b1);
            n_cmp++;
            if ({a_ready, b_ready} !== g) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got ar/br=%b%b, required %b", i, a_ready, b_ready, g);
            end
            if (g[1]) begin exp_q.push_back({8'h10, 8'h11}); m_last_b = 1'b0; end
            else      begin exp_q.push_back({8'h20, 8'h22}); m_last_b = 1'b1; end
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || {a_ready, b_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL rr_drain: got pending=%0d ar/br=%b%b, required 0 and 00",
                     exp_q.size(), a_ready, b_ready);
        end
        tick();
    endtask

    task automatic test_single_b();
        b_valid = 1'b1; b_addr = 8'h05; b_data = 8'hAA;
        @(negedge clk);
        n_cmp++;
        if ({a_ready, b_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL single_b_ready: got ar/br=%b%b, required 01", a_ready, b_ready);
        end
        exp_q.push_back({8'h05, 8'hAA});
        m_last_b = 1'b1;
        tick();
        b_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bram_we, bram_addr, bram_data} !== {1'b1, 8'h05, 8'hAA}) begin
            n_err++;
            $display("FAIL single_b_write: got we=%b addr=%0h data=%0h, required 1 05 aa",
                     bram_we, bram_addr, bram_data);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({bram_we, bram_addr, bram_data} !== {1'b0, 8'h05, 8'hAA}) begin
            n_err++;
            $display("FAIL single_b_idle_hold: got we=%b addr=%0h data=%0h, required 0 05 aa",
                     bram_we, bram_addr, bram_data);
        end
        tick();
    endtask

    task automatic test_arb_patterns();
        logic [1:0] pat [6];
        logic [1:0] g;
        pat = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 2'b11};
        for (int i = 0; i < 6; i++) begin
            a_valid = pat[i][1]; a_addr = 8'(8'h50 + i); a_data = 8'(8'hA0 + i);
            b_valid = pat[i][0]; b_addr = 8'(8'h60 + i); b_data = 8'(8'hB0 + i);
            @(negedge clk);
            g = exp_grant(pat[i][1], pat[i][0]);
            n_cmp++;
            if ({a_ready, b_ready} !== g) begin
                n_err++;
                $display("FAIL pattern_grant[%0d]: got ar/br=%b%b, required %b", i, a_ready, b_ready, g);
            end
            if (g[1])      begin exp_q.push_back({a_addr, a_data}); m_last_b = 1'b0; end
            else if (g[0]) begin exp_q.push_back({b_addr, b_data}); m_last_b = 1'b1; end
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pattern_drain: got pending=%0d, required 0", exp_q.size());
        end
        tick();
    endtask

    task automatic test_clear_with_pending();
        a_valid = 1'b1; a_addr = 8'h30; a_data = 8'h31;
        @(negedge clk);
        n_cmp++;
        if (a_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pre_clear_accept: got ar=%b, required 1", a_ready);
        end
        exp_q.push_back({8'h30, 8'h31});
        m_last_b = 1'b0;
        tick();
        clear_start = 1'b1; clear_data = 8'h3C;
        a_addr = 8'h40; a_data = 8'h41;
        @(negedge clk);
        n_cmp++;
        if ({a_ready, b_ready, clear_busy} !== 3'b000) begin
            n_err++;
            $display("FAIL clear_start_block: got ar/br/busy=%b%b%b, required 000",
                     a_ready, b_ready, clear_busy);
        end
        for (int k = 0; k < DEPTH; k++) exp_q.push_back({8'(k), 8'h3C});
        tick();
        for (int k = 1; k <= DEPTH; k++) begin
            clear_start = (k == 5);
            clear_data = 8'hFF;
            @(negedge clk);
            n_cmp++;
            if ({clear_busy, clear_done, a_ready, b_ready} !== 4'b1000) begin
                n_err++;
                $display("FAIL clear_busy[T+%0d]: got busy/done/ar/br=%b%b%b%b, required 1000",
                         k, clear_busy, clear_done, a_ready, b_ready);
            end
            tick();
        end
        clear_start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({clear_busy, clear_done, a_ready, b_ready} !== 4'b0110) begin
            n_err++;
            $display("FAIL clear_done_pulse: got busy/done/ar/br=%b%b%b%b, required 0110",
                     clear_busy, clear_done, a_ready, b_ready);
        end
        exp_q.push_back({8'h40, 8'h41});
        m_last_b = 1'b0;
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({clear_busy, clear_done} !== 2'b00 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL clear_after: got busy/done=%b%b pending=%0d, required 00 and 0",
                     clear_busy, clear_done, exp_q.size());
        end
        tick();
    endtask

    task automatic test_rst_abort();
        clear_start = 1'b1; clear_data = 8'h5A;
        @(negedge clk);
        for (int k = 0; k <= 50; k++) exp_q.push_back({8'(k), 8'h5A});
        tick();
        for (int k = 1; k <= 51; k++) begin
            clear_start = 1'b0;
            if (k == 51) rst = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (k < 51 && clear_busy !== 1'b1) begin
                n_err++;
                $display("FAIL abort_busy[T+%0d]: got busy=%b, required 1", k, clear_busy);
            end else if (k == 51 && {a_ready, b_ready} !== 2'b00) begin
                n_err++;
                $display("FAIL abort_rst_ready: got ar/br=%b%b, required 00", a_ready, b_ready);
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if ({bram_we, clear_busy, clear_done, a_ready, b_ready} !== 5'b0) begin
            n_err++;
            $display("FAIL abort_in_rst: got we/busy/done/ar/br=%b%b%b%b%b, required 00000",
                     bram_we, clear_busy, clear_done, a_ready, b_ready);
        end
        tick();
        rst = 1'b0;
        m_last_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bram_we, clear_busy, clear_done} !== 3'b000 || exp_q.size() != 0) begin
                n_err++;
                $display("FAIL abort_quiet[%0d]: got we/busy/done=%b%b%b pending=%0d, required 000 and 0",
                         k, bram_we, clear_busy, clear_done, exp_q.size());
            end
            tick();
        end
        clear_start = 1'b1; clear_data = 8'h77;
        @(negedge clk);
        for (int k = 0; k < DEPTH; k++) exp_q.push_back({8'(k), 8'h77});
        tick();
        clear_start = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({clear_busy, clear_done} !== 2'b10) begin
                n_err++;
                $display("FAIL reclear_busy[T+%0d]: got busy/done=%b%b, required 10",
                         k, clear_busy, clear_done);
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if ({clear_busy, clear_done} !== 2'b01 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL reclear_done: got busy/done=%b%b pending=%0d, required 01 and 0",
                     clear_busy, clear_done, exp_q.size());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_b();
        test_arb_patterns();
        test_clear_with_pending();
        test_rst_abort();
        repeat (2) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL final_drain: got pending=%0d, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bram_wr_arb.md
BRAM_WR_ARB -- requirements
Module: bram_wr_arb

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 256, number of memory words; any value >= 2, not necessarily a power of two.
REQ-003 Parameter ADDRW, default $clog2(DEPTH), address width in bits.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 a_valid  input  1  requester A has a write pending.
REQ-007 a_ready  output  1  requester A write is accepted this cycle.
REQ-008 a_addr / a_data  input  ADDRW / WIDTH  requester A write address and data.
REQ-009 b_valid, b_ready, b_addr, b_data  same directions and widths as A  requester B.
REQ-010 clear_start  input  1  request to fill the whole memory with clear_data.
REQ-011 clear_data  input  WIDTH  fill value; sampled in the clear_start acceptance cycle.
REQ-012 clear_busy  output  1  a clear sequence is in progress.
REQ-013 clear_done  output  1  one-cycle pulse when a clear completes.
REQ-014 bram_we / bram_addr / bram_data  output  1 / ADDRW / WIDTH  registered drive to the BRAM write port.

Function
REQ-015 A write is accepted in a cycle when valid && ready for that requester; the handshake is valid/ready.
REQ-016 a_ready and b_ready are combinational and are both low when clear_busy=1 or clear_start=1.
REQ-017 In any cycle, at most one of a_ready or b_ready is high.
REQ-018 Only one requester valid, not blocked: that requester's ready is high.
REQ-019 Both requesters valid, not blocked: round-robin; the ready goes to the requester not granted most recently.
REQ-020 The last-grant register updates only on an accepted write.
REQ-021 Write accepted in cycle N: bram_we=1 in cycle N+1, with bram_addr and bram_data equal to that requester's addr and data from cycle N.
REQ-022 No write accepted and no clear write scheduled: bram_we=0 next cycle; bram_addr and bram_data hold their previous values.
REQ-023 The clear FSM has two states, IDLE and CLEAR.
REQ-024 IDLE -> CLEAR when clear_start=1 at a clock edge; clear_data is latched at that edge.
REQ-025 clear_start asserted while in CLEAR is ignored; it does not restart and is not queued.
REQ-026 clear_start in cycle T: bram_we=1 in each cycle T+1 through T+DEPTH, bram_addr=k in cycle T+1+k (k = 0 to DEPTH-1), and bram_data = latched value.
REQ-027 clear_busy=1 in cycles T+1 through T+DEPTH; CLEAR -> IDLE after the write to address DEPTH-1.
REQ-028 clear_done=1 only in cycle T+DEPTH+1; requesters may be accepted from cycle T+DEPTH+1 onward.
REQ-029 The clear address counter is ADDRW bits wide and stops at DEPTH-1; it never wraps past DEPTH-1 or writes address >= DEPTH.
REQ-030 Requester valid in the same cycle as clear_start: the clear wins; the requester is not accepted and must hold valid.
REQ-031 A write accepted in the cycle before clear_start still issues; it appears on bram_* in the cycle clear_start is high.
REQ-032 No requester write is lost or duplicated.

Reset
REQ-033 While rst=1: bram_we=0, bram_addr=0, bram_data=0, clear_busy=0, clear_done=0, a_ready=0, b_ready=0.
REQ-034 While rst=1: FSM=IDLE, clear counter=0, last-grant=B, so A wins the first tie.
REQ-035 rst during CLEAR aborts the sequence: no further clear writes, no clear_done pulse.
REQ-036 After rst deasserts, arbitration resumes in the next cycle.

Verification
REQ-037 Out of reset, a_valid=b_valid=1 held with addr A=0x10/data 0x11 and addr B=0x20/data 0x22 -> bram_we writes alternate A, B, A, B starting in cycle 1.
REQ-038 Only b_valid with addr 0x05/data 0xAA in cycle N -> b_ready=1 in cycle N; bram_we=1, addr 0x05, data 0xAA in cycle N+1; bram_we=0 in N+2 if b_valid drops.
REQ-039 DEPTH=256, clear_start with clear_data=0x3C in cycle T -> addresses 0..255 written with 0x3C in cycles T+1..T+256, clear_done pulse in T+257, and ready stays low throughout.
REQ-040 DEPTH=200 clear -> exactly 200 writes, last address 199, no write to addresses 200..255.
REQ-041 clear_start and a_valid in the same cycle -> a_ready=0 in that cycle; the A write lands in cycle T+DEPTH+2 after being accepted in cycle T+DEPTH+1.
REQ-042 rst asserted at clear write k=50 -> bram_we=0 from the next cycle, clear_busy=0, no clear_done; then a fresh clear restarts at address 0.
